// File: rtl/lcd_screen_scheduler_if.sv
// Bus between the clock/alarm core and the LCD screen scheduler.
// The master side raises screen requests and UI mode codes; the slave side
// (the scheduler) returns the page/mode selects consumed by the pixel generator.
interface lcd_screen_scheduler_if;
   logic [2:0] mode;
   logic [2:0] alarm_req;
   logic       alarm_ack;
   logic       hourly_req;
   logic       temp_valid;
   logic [1:0] page_sel;
   logic [1:0] alarm_id;
   logic [2:0] display_mode;
   logic       blink;
   logic       sec_tick;

   modport master (
      output mode, alarm_req, alarm_ack, hourly_req, temp_valid,
      input  page_sel, alarm_id, display_mode, blink, sec_tick
   );

   modport slave (
      input  mode, alarm_req, alarm_ack, hourly_req, temp_valid,
      output page_sel, alarm_id, display_mode, blink, sec_tick
   );
endinterface

// File: rtl/lcd_screen_scheduler.sv
// LCD screen scheduler: picks the page the pixel engine draws each cycle
// (clock, temp/humidity, alarm pop-up, hourly chime), owns the 12h/24h latch
// and generates the alarm blink phase and a one-second tick.
// Optional feature macro: SCHED_AUTO_ROTATE_EN enables the CLOCK/TEMP
// auto-rotation; when it is undefined the TEMP page is never selected.
module lcd_screen_scheduler #(
   parameter int CLK_HZ         = 27000000,
   parameter int ROTATE_SEC     = 10,
   parameter int TEMP_SEC       = 3,
   parameter int ALARM_HOLD_SEC = 30,
   parameter int CHIME_SEC      = 5
) (
   input  logic                 XTAL_IN,
   input  logic                 Reset_Button,
   lcd_screen_scheduler_if.slave bus
);

   localparam int HALF_CYCLES = CLK_HZ / 2;
   localparam int PRESC_W     = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam int MAX_AB      = (ROTATE_SEC > TEMP_SEC) ? ROTATE_SEC : TEMP_SEC;
   localparam int MAX_CD      = (ALARM_HOLD_SEC > CHIME_SEC) ? ALARM_HOLD_SEC : CHIME_SEC;
   localparam int DWELL_MAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int DWELL_W     = $clog2(DWELL_MAX + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(HALF_CYCLES - 1);
   localparam logic [DWELL_W-1:0] ROTATE_D   = DWELL_W'(ROTATE_SEC);
   localparam logic [DWELL_W-1:0] HOLD_D     = DWELL_W'(ALARM_HOLD_SEC);
   localparam logic [DWELL_W-1:0] CHIME_D    = DWELL_W'(CHIME_SEC);
   localparam logic [DWELL_W-1:0] DWELL_TOP  = DWELL_W'(DWELL_MAX);
`ifdef SCHED_AUTO_ROTATE_EN
   localparam logic [DWELL_W-1:0] TEMP_D     = DWELL_W'(TEMP_SEC);
`endif

   // State codes double as the page_sel encoding.
   typedef enum logic [1:0] {
      ST_CLOCK = 2'd0,
      ST_TEMP  = 2'd1,
      ST_ALARM = 2'd2,
      ST_CHIME = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic                 half_phase_q, half_phase_d;
   logic                 sec_tick_q, sec_tick_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   dwell_cap;
   logic [2:0]           mask_q, mask_d;
   logic                 chime_pending_q, chime_pending_d;
   logic [1:0]           alarm_id_q, alarm_id_d;
   logic                 blink_q, blink_d;
   logic [2:0]           display_mode_q, display_mode_d;

   logic                 half_tick;
   logic                 sec_now;
   logic [2:0]           unmasked;
   logic [2:0]           cur_mask;
   logic [2:0]           mask_set;
   logic [2:0]           remaining;
   logic                 pend;
   logic                 alarm_exit;
   logic                 dwell_clear;

`ifndef SCHED_AUTO_ROTATE_EN
   logic                 unused_temp_valid;
   assign unused_temp_valid = bus.temp_valid;
`endif

   // Alarm 1 wins over 2 over 3; result is the 1-based alarm number or 0.
   function automatic logic [1:0] lowest_id(input logic [2:0] req);
      logic [1:0] id;
      id = 2'd0;
      if (req[0])      id = 2'd1;
      else if (req[1]) id = 2'd2;
      else if (req[2]) id = 2'd3;
      return id;
   endfunction

   // Half-second prescaler, second tick and the 12h/24h latch.
   always_comb begin
      half_tick      = (presc_q == PRESC_LAST);
      presc_d        = half_tick ? '0 : presc_q + PRESC_W'(1);
      half_phase_d   = half_tick ? ~half_phase_q : half_phase_q;
      sec_now        = half_tick & half_phase_q;
      sec_tick_d     = sec_now;
      display_mode_d = display_mode_q;
      if (bus.mode == 3'd3)      display_mode_d = 3'd1;
      else if (bus.mode == 3'd4) display_mode_d = 3'd0;
   end

   // Page arbitration, alarm masking, chime queueing and dwell counting.
   always_comb begin
      state_d         = state_q;
      alarm_id_d      = alarm_id_q;
      chime_pending_d = chime_pending_q;
      blink_d         = 1'b0;
      mask_set        = 3'b000;
      remaining       = 3'b000;
      pend            = 1'b0;
      alarm_exit      = 1'b0;
      dwell_clear     = 1'b0;
      unmasked        = bus.alarm_req & ~mask_q;
      case (alarm_id_q)
         2'd1:    cur_mask = 3'b001;
         2'd2:    cur_mask = 3'b010;
         2'd3:    cur_mask = 3'b100;
         default: cur_mask = 3'b000;
      endcase

      if (state_q == ST_ALARM) begin
         blink_d         = half_tick ? ~blink_q : blink_q;
         pend            = chime_pending_q | bus.hourly_req;
         chime_pending_d = pend;
         if (bus.alarm_ack || (dwell_q == HOLD_D)) mask_set = cur_mask;
         alarm_exit = bus.alarm_ack || ((bus.alarm_req & cur_mask) == 3'b000) ||
                      (dwell_q == HOLD_D);
         if (alarm_exit) begin
            remaining   = bus.alarm_req & ~(mask_q | mask_set);
            dwell_clear = 1'b1;
            if (remaining != 3'b000) begin
               alarm_id_d = lowest_id(remaining);
               blink_d    = 1'b1;
            end else begin
               alarm_id_d = 2'd0;
               blink_d    = 1'b0;
               if (pend) begin
                  state_d         = ST_CHIME;
                  chime_pending_d = 1'b0;
               end else begin
                  state_d = ST_CLOCK;
               end
            end
         end
      end else if (unmasked != 3'b000) begin
         state_d     = ST_ALARM;
         alarm_id_d  = lowest_id(unmasked);
         blink_d     = 1'b1;
         dwell_clear = 1'b1;
         if (bus.hourly_req) chime_pending_d = 1'b1;
      end else begin
         case (state_q)
            ST_CLOCK: begin
               if (chime_pending_q || bus.hourly_req) begin
                  state_d         = ST_CHIME;
                  chime_pending_d = 1'b0;
               end
`ifdef SCHED_AUTO_ROTATE_EN
               else if ((dwell_q == ROTATE_D) && bus.temp_valid) begin
                  state_d = ST_TEMP;
               end
`endif
            end
            ST_TEMP: begin
`ifdef SCHED_AUTO_ROTATE_EN
               if (chime_pending_q || bus.hourly_req) begin
                  state_d         = ST_CHIME;
                  chime_pending_d = 1'b0;
               end else if (!bus.temp_valid || (dwell_q == TEMP_D)) begin
                  state_d = ST_CLOCK;
               end
`else
               state_d = ST_CLOCK;
`endif
            end
            ST_CHIME: begin
               if (dwell_q == CHIME_D) state_d = ST_CLOCK;
            end
            default: state_d = ST_CLOCK;
         endcase
      end

      mask_d    = (mask_q | mask_set) & bus.alarm_req;
      dwell_cap = (state_q == ST_CLOCK) ? ROTATE_D : DWELL_TOP;
      if ((state_d != state_q) || dwell_clear)   dwell_d = '0;
      else if (sec_now && (dwell_q < dwell_cap)) dwell_d = dwell_q + DWELL_W'(1);
      else                                       dwell_d = dwell_q;
   end

   // All state registers; reset abandons any alarm and clears the queue.
   always_ff @(posedge XTAL_IN) begin
      if (Reset_Button) begin
         state_q         <= ST_CLOCK;
         presc_q         <= '0;
         half_phase_q    <= 1'b0;
         sec_tick_q      <= 1'b0;
         dwell_q         <= '0;
         mask_q          <= 3'b000;
         chime_pending_q <= 1'b0;
         alarm_id_q      <= 2'd0;
         blink_q         <= 1'b0;
         display_mode_q  <= 3'd0;
      end else begin
         state_q         <= state_d;
         presc_q         <= presc_d;
         half_phase_q    <= half_phase_d;
         sec_tick_q      <= sec_tick_d;
         dwell_q         <= dwell_d;
         mask_q          <= mask_d;
         chime_pending_q <= chime_pending_d;
         alarm_id_q      <= alarm_id_d;
         blink_q         <= blink_d;
         display_mode_q  <= display_mode_d;
      end
   end

   assign bus.page_sel     = state_q;
   assign bus.alarm_id     = alarm_id_q;
   assign bus.display_mode = display_mode_q;
   assign bus.blink        = blink_q;
   assign bus.sec_tick     = sec_tick_q;

endmodule

// File: doc/lcd_screen_scheduler.md
Name: lcd_screen_scheduler

Overview:
Decides each cycle which screen the LCD pixel engine draws. The screens are the clock page, the temperature/humidity page, an alarm pop-up and an hourly-chime banner. The block arbitrates between alarm, chime and auto-rotation requests, owns the 12h/24h display-mode latch, and generates the alarm blink phase. It sits between the clock/alarm core and the LCD top, and its outputs feed the pixel generator's page and mode selects.

Parameters:
CLK_HZ, 27000000, XTAL_IN frequency; half-second tick every CLK_HZ/2 cycles
ROTATE_SEC, 10, seconds on clock page before rotating to temp page
TEMP_SEC, 3, seconds on temp page before returning to clock page
ALARM_HOLD_SEC, 30, max seconds an unacknowledged alarm pop-up is shown
CHIME_SEC, 5, seconds the hourly-chime banner is shown

Ports:
XTAL_IN  in  1  system clock; sole clock
Reset_Button  in  1  synchronous, active-high reset
mode  in  3  UI mode code; 3 selects 12h, 4 selects 24h
alarm_req  in  3  level; bit n = alarm n+1 ringing
alarm_ack  in  1  one-cycle pulse, user dismisses the current alarm
hourly_req  in  1  one-cycle pulse at top of hour (chime enabled)
temp_valid  in  1  level; TempHumi data valid
page_sel  out  2  0 clock, 1 temp, 2 alarm, 3 chime
alarm_id  out  2  1..3 while page_sel=2, else 0
display_mode  out  3  0 = 24h, 1 = 12h
blink  out  1  alarm highlight phase
sec_tick  out  1  one-cycle pulse per second

Behaviour:
- Reset (sync, high): state CLOCK; page_sel, alarm_id, display_mode, blink and sec_tick all 0; prescaler, dwell counter, masks and chime_pending all 0. Reset mid-alarm abandons the alarm.
- Prescaler: free-running 0..CLK_HZ/2-1; half_tick when it wraps. sec_tick fires on every second half_tick. A state change does not reset the prescaler, so the first second in a state may be short.
- display_mode: registered with 1-cycle latency. mode==3 -> 1; mode==4 -> 0; any other value holds.
- Dwell counter: counts sec_ticks and clears on every state change.
- States and priority: ALARM > CHIME > TEMP rotation > CLOCK. page_sel is registered and equals the state code.
- CLOCK
  - If dwell==ROTATE_SEC and temp_valid=1 -> TEMP.
  - If temp_valid=0, dwell saturates at ROTATE_SEC and the state moves to TEMP the cycle after temp_valid rises.
  - If chime_pending or hourly_req -> CHIME.
- TEMP
  - dwell==TEMP_SEC -> CLOCK.
  - temp_valid falls -> CLOCK on the next edge.
  - hourly_req -> CHIME.
- CHIME: dwell==CHIME_SEC -> CLOCK. Entry clears chime_pending.
- ALARM entry, from any state including CHIME:
  - Condition: (alarm_req & ~mask) != 0.
  - alarm_id latches the lowest set unmasked bit (+1). alarm1 has highest priority.
  - blink is forced to 1 on entry.
  - A CHIME preempted by ALARM is dropped, not re-queued.
- ALARM exit triggers:
  - alarm_ack: set mask[id].
  - alarm_req[id] deasserts.
  - dwell==ALARM_HOLD_SEC: set mask[id].
- After ALARM exit:
  - If another unmasked request is pending, stay in ALARM, load the new id and restart dwell.
  - Otherwise, if chime_pending -> CHIME; else -> CLOCK.
- Masks: mask[n] clears whenever alarm_req[n]=0. A held request therefore cannot re-trigger until it is released and reasserted.
- hourly_req while in ALARM sets chime_pending (single depth; further pulses are ignored). hourly_req in the same cycle as an alarm entry: ALARM wins and chime_pending is set.
- blink: toggles on every half_tick while in ALARM; 0 in all other states.
- alarm_ack outside ALARM is ignored.

Optional Feature:
SCHED_AUTO_ROTATE_EN
- Defined: CLOCK/TEMP auto-rotation as above.
- Undefined: TEMP is unreachable, page_sel never equals 1, temp_valid is ignored, and CLOCK dwell only counts (no transition).

Test Plan:
Bench parameters: CLK_HZ=20, ROTATE_SEC=3, TEMP_SEC=2, ALARM_HOLD_SEC=4, CHIME_SEC=2. Half-tick every 10 cycles.
1. Reset, then mode=3 for 1 cycle -> display_mode=1 next edge; mode=2 -> stays 1; mode=4 -> 0. Reset pulse -> 0.
2. temp_valid=1, no requests -> page_sel 0 for 3 sec_ticks, then 1 for 2 sec_ticks, then 0. Dropping temp_valid while page_sel=1 -> 0 next edge. With the macro undefined -> page_sel stays 0.
3. alarm_req=3'b110 -> page_sel=2, alarm_id=2. ack -> alarm_id=3. ack -> page_sel=0. With both req bits still high, no re-entry; drop and reassert bit 1 -> alarm_id=2.
4. alarm_req=3'b001 held, no ack -> blink 1 then toggling every 10 cycles. Exit to page_sel=0 at the 4th sec_tick; blink=0 and mask holds.
5. hourly_req coincident with alarm_req[2] rising -> page_sel=2, alarm_id=3. After ack -> page_sel=3 for 2 sec_ticks, then 0.
6. Reset_Button high mid-alarm with alarm_req held -> all outputs 0 next edge. After release -> page_sel=2 again (masks cleared).
